// File: rtl/spi_shift_engine.sv
// SPI shift engine: gates the free-running sclk onto the pad for len bit periods, shifting
// tx_data out on mosi and miso into rx_data. Define SPI_SHIFT_IRQ_EN for the sticky irq.
module spi_shift_engine #(
    parameter int MAX_LEN = 32
) (
    input  logic               wb_clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               go,
    input  logic [5:0]         len,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               miso,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               busy,
    output logic               done,
    output logic               mosi,
    output logic               sclk_pad,
    output logic               irq,
    input  logic               irq_ack
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;
    state_t state, state_d;

    logic               sclk_q;
    logic [MAX_LEN-1:0] tx_l;
    logic [LW-1:0]      len_l;
    logic               cpol_l, cpha_l, lsb_l;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;

    logic [LW-1:0] len_eff;
    logic          rise, fall, first_lead, last_trail, sample, advance;

    assign len_eff    = (len == 6'd0) ? LW'(MAX_LEN) : LW'(len);
    assign rise       = sclk & ~sclk_q;
    assign fall       = ~sclk & sclk_q;
    // cnt still holds its loaded value only before the very first leading edge
    assign first_lead = rise && (cnt == {len_l, 1'b0});
    assign last_trail = fall && (cnt == CW'(1));
    assign sample     = cpha_l ? fall : rise;
    assign advance    = cpha_l ? (rise && !first_lead) : (fall && !last_trail);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (go) state_d = SYNC;
            SYNC:    if (fall) state_d = RUN;
            RUN:     if (last_trail) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sclk_q  <= 1'b0;
            tx_l    <= '0;
            len_l   <= '0;
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
            lsb_l   <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            rx_data <= '0;
        end else begin
            state  <= state_d;
            sclk_q <= sclk;
            case (state)
                IDLE: if (go) begin
                    tx_l    <= tx_data;
                    len_l   <= len_eff;
                    cpol_l  <= cpol;
                    cpha_l  <= cpha;
                    lsb_l   <= lsb;
                    idx     <= lsb ? '0 : IW'(len_eff - LW'(1));
                    rx_data <= '0;
                end
                SYNC: if (fall) cnt <= {len_l, 1'b0};
                RUN: begin
                    if (rise || fall) cnt <= cnt - CW'(1);
                    if (sample) begin
                        if (lsb_l) rx_data[idx] <= miso;
                        else       rx_data <= {rx_data[MAX_LEN-2:0], miso};
                    end
                    if (advance) idx <= lsb_l ? idx + IW'(1) : idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Pad follows sclk only while running; RUN is entered right after a fall, so no runts
    always_comb begin
        sclk_pad = cpol_l;
        case (state)
            IDLE:    sclk_pad = cpol;
            RUN:     sclk_pad = cpol_l ^ sclk;
            default: sclk_pad = cpol_l;
        endcase
    end

    assign mosi = (state == IDLE) ? 1'b0 : tx_l[idx];
    assign busy = (state == SYNC) || (state == RUN);
    assign done = (state == DONE);

`ifdef SPI_SHIFT_IRQ_EN
    // Set on entry to DONE so irq rises with done; an ack during DONE loses to the set
    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset)                                 irq <= 1'b0;
        else if (state_d == DONE || state == DONE) irq <= 1'b1;
        else if (irq_ack)                          irq <= 1'b0;
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq = 1'b0;
`endif

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Serial transfer engine directly downstream of the SPI clock generator. It consumes the free-running `sclk` generated in the `wb_clk` domain and detects its edges synchronously. It gates that clock onto the SPI pad for exactly `len` bit periods, shifting `tx_data` out on `mosi` and collecting `miso` into `rx_data`, in any of the four CPOL/CPHA modes, MSB- or LSB-first. Its control and data ports are driven by the Wishbone register layer.

## Interface
- `MAX_LEN`, 32: maximum transfer length in bits; width of `tx_data`/`rx_data`.
- `wb_clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `sclk` in 1: free-running divided clock from the clock generator, registered in the `wb_clk` domain.
- `go` in 1: start request; sampled only in IDLE.
- `len` in 6: transfer length, 1..`MAX_LEN`; 0 means `MAX_LEN`.
- `cpol` in 1: pad clock idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `lsb` in 1: 1 = LSB first.
- `tx_data` in `MAX_LEN`: transmit word; right-justified, bits [len-1:0] used.
- `miso` in 1: serial input.
- `rx_data` out `MAX_LEN`: received word; right-justified, upper bits zero.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `mosi` out 1: serial output.
- `sclk_pad` out 1: gated SPI clock to the pad.
- `irq` out 1: sticky completion interrupt (see Configuration).
- `irq_ack` in 1: clears `irq`.

## Operation
- States:
  - IDLE: `go` moves to SYNC and latches `tx_data`, `len`, `cpol`, `cpha`, `lsb`; `rx_data` is cleared to 0.
  - SYNC: waits for a falling edge of `sclk`, then moves to RUN.
  - RUN: transfer proceeds; after the final edge, moves to DONE.
  - DONE: one cycle only, then returns to IDLE.
- Edge detect: `sclk_q` holds `sclk` delayed one `wb_clk` cycle.
  - rise = `sclk` & ~`sclk_q`; fall = ~`sclk` & `sclk_q`.
  - In RUN, rise is the leading edge and fall is the trailing edge.
- `sclk_pad`:
  - In RUN: `cpol_l` ^ `sclk`.
  - Otherwise: live `cpol` input when IDLE, `cpol_l` when SYNC/DONE.
  - This yields exactly `len` pad pulses, with no runt pulses.
- Edge counter:
  - Loaded with 2×len (7 bits) at SYNC→RUN.
  - Decrements on every rise and fall in RUN.
  - RUN→DONE when a trailing edge drops it to 0.
- Bit index:
  - MSB-first: starts at len-1 and decrements.
  - LSB-first: starts at 0 and increments.
  - `mosi` = `tx_l`[index]. `mosi` is 0 in IDLE and equals the first bit from SYNC onward.
- CPHA=0:
  - First bit is valid on `mosi` from SYNC.
  - Leading edge: sample `miso`.
  - Trailing edge: advance index; suppressed after the last bit.
- CPHA=1:
  - First leading edge: drives bit 0 of the sequence (index unchanged).
  - Later leading edges: advance index.
  - Trailing edge: sample `miso`.
- Sampling:
  - MSB-first: `rx_data` <= {`rx_data`[MAX_LEN-2:0], `miso`}.
  - LSB-first: `rx_data`[index] <= `miso`.
- `busy` is 1 in SYNC and RUN; `done` is 1 in DONE.
- `go` while not in IDLE is ignored, including during the DONE cycle.
- `rx_data` holds its value until the next accepted `go`.

## Timing
- Reset values:
  - Outputs: `busy`=0, `done`=0, `mosi`=0, `irq`=0, `rx_data`=0, `sclk_pad`=`cpol`.
  - Internal state: IDLE, `sclk_q`=0.
- Edge actions register one `wb_clk` after `sclk` changes.
  - `mosi` therefore lags the pad edge by 1 cycle.
  - One half period (`divider`+1 cycles) is available for setup. `divider`=0 is supported.
- Start latency: `go` → `busy` is 1 cycle; SYNC → RUN takes at most 2×(`divider`+1) cycles.
- Transfer duration: RUN lasts 2×len half periods.
- `done`/`busy` fall occur in the cycle after the final trailing edge is detected; `rx_data` is final in that same cycle.
- Reset mid-transfer:
  - Immediate return to IDLE with reset values.
  - No `done` pulse; partial `rx_data` is discarded (cleared).

## Configuration
- `SPI_SHIFT_IRQ_EN` defined:
  - `irq` sets on the DONE cycle and holds until `irq_ack`.
  - When set and `irq_ack` coincide in the same cycle, set wins.
- Not defined: `irq` is tied to 0 and `irq_ack` is ignored; the ports remain present.

## Test plan
- Mode 0, MSB-first, len=8, tx=0xA5, `miso` looped to `mosi`, `divider`=2:
  - Exactly 8 `sclk_pad` pulses, idle low; `mosi` 1,0,1,0,0,1,0,1.
  - `rx_data`=0x000000A5; `done` is a single pulse.
- Mode 3, LSB-first, len=12, tx=0x5C3, `miso` fed from a model slave sending 0x9E1:
  - Pad idle high; `rx_data`=0x000009E1.
  - Bits change on leading edges and are sampled on trailing edges.
- len=0, tx=0xDEADBEEF, loopback, `divider`=0:
  - 32 pulses; `rx_data`=0xDEADBEEF; `busy` high 65..66 cycles plus SYNC wait.
- `go` pulsed during RUN and again during the DONE cycle:
  - Both ignored; a `go` one cycle after DONE starts a new transfer.
- Reset asserted after 3 bits of a len=8 transfer:
  - `busy`=0, `mosi`=0, `rx_data`=0, no `done`.
  - `sclk_pad` returns to `cpol` asynchronously.
- With `SPI_SHIFT_IRQ_EN`:
  - `irq` rises with `done` and stays high.
  - `irq_ack` clears it next cycle.
  - `irq_ack` coincident with a new `done` leaves `irq`=1.
